// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, mux select codes,
// trap causes and the decoder instruction ids with class helpers.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALT
   } state_t;

   // pc_sel codes
   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_REL   = 2'b01;
   localparam logic [1:0] PC_JALR  = 2'b10;
   localparam logic [1:0] PC_TRAP  = 2'b11;

   // wb_sel codes
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_CSR  = 2'b11;

   // trap_cause codes
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
   localparam logic [1:0] CAUSE_ECALL   = 2'd1;
   localparam logic [1:0] CAUSE_BUS     = 2'd2;

   // Instruction ids as produced by the decoder (RV32I + Zicsr order)
   localparam logic [5:0] ID_LUI    = 6'd0;
   localparam logic [5:0] ID_AUIPC  = 6'd1;
   localparam logic [5:0] ID_JAL    = 6'd2;
   localparam logic [5:0] ID_JALR   = 6'd3;
   localparam logic [5:0] ID_BEQ    = 6'd4;
   localparam logic [5:0] ID_BNE    = 6'd5;
   localparam logic [5:0] ID_BLT    = 6'd6;
   localparam logic [5:0] ID_BGE    = 6'd7;
   localparam logic [5:0] ID_BLTU   = 6'd8;
   localparam logic [5:0] ID_BGEU   = 6'd9;
   localparam logic [5:0] ID_LB     = 6'd10;
   localparam logic [5:0] ID_LH     = 6'd11;
   localparam logic [5:0] ID_LW     = 6'd12;
   localparam logic [5:0] ID_LBU    = 6'd13;
   localparam logic [5:0] ID_LHU    = 6'd14;
   localparam logic [5:0] ID_SB     = 6'd15;
   localparam logic [5:0] ID_SH     = 6'd16;
   localparam logic [5:0] ID_SW     = 6'd17;
   localparam logic [5:0] ID_ADDI   = 6'd18;
   localparam logic [5:0] ID_ADD    = 6'd27;
   localparam logic [5:0] ID_FENCE  = 6'd37;
   localparam logic [5:0] ID_ECALL  = 6'd38;
   localparam logic [5:0] ID_EBREAK = 6'd39;
   localparam logic [5:0] ID_CSRRW  = 6'd40;
   localparam logic [5:0] ID_CSRRS  = 6'd41;
   localparam logic [5:0] ID_CSRRC  = 6'd42;
   localparam logic [5:0] ID_CSRRWI = 6'd43;
   localparam logic [5:0] ID_CSRRSI = 6'd44;
   localparam logic [5:0] ID_CSRRCI = 6'd45;
   localparam logic [5:0] ILLEGAL_ID = 6'd63;

   function automatic logic is_load(input logic [5:0] id);
      return id inside {ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU};
   endfunction

   function automatic logic is_store(input logic [5:0] id);
      return id inside {ID_SB, ID_SH, ID_SW};
   endfunction

   function automatic logic is_branch(input logic [5:0] id);
      return id inside {ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU};
   endfunction

   function automatic logic is_csr(input logic [5:0] id);
      return id inside {ID_CSRRW, ID_CSRRS, ID_CSRRC, ID_CSRRWI, ID_CSRRSI, ID_CSRRCI};
   endfunction

endpackage

// File: rtl/multicycle_ctrl_timeout_cnt.sv
// Bus-wait watchdog: counts cycles spent waiting for an ack and flags expiry
// in the MEM_TIMEOUT-th waiting cycle, so an ack in that same cycle still wins.
module ctrl_timeout_cnt #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int TO_W = 16;

   logic [TO_W-1:0] cnt;

   assign expired = (cnt == TO_W'(MEM_TIMEOUT - 1));

   // Clear on every state change, otherwise count up and saturate at expiry
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + TO_W'(1);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/writeback, raises
// traps on illegal/ecall/bus timeout, halts on ebreak, counts retirements.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [5:0]       instr_id,
   input  logic             br_taken,
   output logic             mem_req,
   output logic             mem_we,
   input  logic             mem_ack,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             csr_we,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic             halt,
   output logic [CNT_W-1:0] instret
);
   state_t     state, state_nxt;
   logic [1:0] cause_nxt;
   logic [5:0] id_q;
   logic       waiting;
   logic       expired;

   assign waiting = (state == S_FETCH) || (state == S_MEM);

   ctrl_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_nxt != state),
      .en      (waiting),
      .expired (expired)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_RESET;
      else     state <= state_nxt;
   end

   // Next-state logic and the cause of any trap being entered
   always_comb begin
      state_nxt = state;
      cause_nxt = CAUSE_ILLEGAL;
      case (state)
         S_RESET:  state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ack) state_nxt = S_DECODE;
            else if (expired) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_BUS;
            end
         end
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            if (instr_id == ILLEGAL_ID) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_ILLEGAL;
            end else if (instr_id == ID_ECALL) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_ECALL;
            end else if (instr_id == ID_EBREAK)
               state_nxt = S_HALT;
            else if (is_load(instr_id) || is_store(instr_id))
               state_nxt = S_MEM;
            else if (is_branch(instr_id))
               state_nxt = S_FETCH;
            else
               state_nxt = S_WB;
         end
         S_MEM: begin
            if (mem_ack) state_nxt = is_store(id_q) ? S_FETCH : S_WB;
            else if (expired) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_BUS;
            end
         end
         S_WB:     state_nxt = S_FETCH;
         S_TRAP:   state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_RESET;
      endcase
   end

   // Outputs: decoded from state; branch/store PC strobes also use the
   // same-cycle compare result and ack so the PC moves in that cycle
   always_comb begin
      imem_req = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = PC_PLUS4;
      rf_we    = 1'b0;
      wb_sel   = WB_ALU;
      csr_we   = 1'b0;
      trap     = 1'b0;
      halt     = 1'b0;
      case (state)
         S_FETCH: imem_req = 1'b1;
         S_EXEC: begin
            if (is_branch(instr_id)) begin
               pc_we  = 1'b1;
               pc_sel = br_taken ? PC_REL : PC_PLUS4;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store(id_q);
            if (mem_ack && is_store(id_q)) pc_we = 1'b1;
         end
         S_WB: begin
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            csr_we = is_csr(id_q);
            if (is_load(id_q))                         wb_sel = WB_LOAD;
            else if (id_q == ID_JAL || id_q == ID_JALR) wb_sel = WB_PC4;
            else if (is_csr(id_q))                     wb_sel = WB_CSR;
            if (id_q == ID_JAL)       pc_sel = PC_REL;
            else if (id_q == ID_JALR) pc_sel = PC_JALR;
         end
         S_TRAP: begin
            trap   = 1'b1;
            pc_we  = 1'b1;
            pc_sel = PC_TRAP;
         end
         S_HALT: halt = 1'b1;
         default: ;
      endcase
   end

   // Hold the decoded id past EXEC so MEM/WB do not depend on the decoder
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  id_q <= '0;
      else if (state == S_EXEC) id_q <= instr_id;
   end

   // Latch the cause when a trap is entered; held until the next trap
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     trap_cause <= CAUSE_ILLEGAL;
      else if (state_nxt == S_TRAP) trap_cause <= cause_nxt;
   end

   // Every PC update except the trap redirect retires an instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          instret <= '0;
      else if (pc_we && state != S_TRAP) instret <= instret + CNT_W'(1);
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of instructions with expected
// per-instruction signatures, plus reset, wrap and halt sequences.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   localparam int TO = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          imem_req, imem_ack = 1'b0;
   logic [5:0]    instr_id = '0;
   logic          br_taken = 1'b0;
   logic          mem_req, mem_we, mem_ack = 1'b0;
   logic          pc_we, rf_we, csr_we, trap, halt;
   logic [1:0]    pc_sel, wb_sel, trap_cause;
   logic [CW-1:0] instret;

   int n_chk = 0;
   int n_err = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack),
      .instr_id(instr_id), .br_taken(br_taken), .mem_req(mem_req),
      .mem_we(mem_we), .mem_ack(mem_ack), .pc_we(pc_we), .pc_sel(pc_sel),
      .rf_we(rf_we), .wb_sel(wb_sel), .csr_we(csr_we), .trap(trap),
      .trap_cause(trap_cause), .halt(halt), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cycles, rf_n, pc_n, pc_sel, wb_sel, csr_n, mem_n, mem_we, trap_n, cause, dret;
   } res_t;

   typedef struct {
      logic [5:0] id;
      bit         br;
      int         flat;  // FETCH cycle carrying imem_ack (0 = never)
      int         mlat;  // MEM cycle carrying mem_ack (0 = never)
      res_t       e;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] id, input bit br, input int flat, input int mlat,
                               input int cy, input int rf, input int pc, input int ps, input int ws,
                               input int cs, input int mn, input int mw, input int tn, input int ca,
                               input int dr);
      vec_t v;
      v.id = id; v.br = br; v.flat = flat; v.mlat = mlat;
      v.e.cycles = cy; v.e.rf_n = rf; v.e.pc_n = pc; v.e.pc_sel = ps; v.e.wb_sel = ws;
      v.e.csr_n = cs; v.e.mem_n = mn; v.e.mem_we = mw; v.e.trap_n = tn; v.e.cause = ca;
      v.e.dret = dr;
      return v;
   endfunction

   // Runs one instruction from the first FETCH cycle (called just after a
   // negedge) until the FSM is back in FETCH; ends just after a negedge.
   task automatic run_vec(input vec_t v, output res_t r, output bit done);
      int fcyc, mcyc;
      bit left;
      logic [CW-1:0] start;
      r = '{default: 0};
      fcyc = 0; mcyc = 0; left = 0; done = 0;
      start = instret;
      instr_id = v.id;
      br_taken = v.br;
      for (int c = 0; c < 40; c++) begin
         if (imem_req && left) begin
            done = 1;
            break;
         end
         if (!imem_req) left = 1;
         r.cycles++;
         if (imem_req) fcyc++;
         if (mem_req) mcyc++;
         imem_ack = imem_req && (fcyc == v.flat);
         mem_ack  = mem_req && (mcyc == v.mlat);
         #1;
         if (pc_we) begin r.pc_n++; r.pc_sel = int'(pc_sel); end
         if (rf_we) begin r.rf_n++; r.wb_sel = int'(wb_sel); end
         if (csr_we) r.csr_n++;
         if (mem_req) begin r.mem_n++; if (mem_we) r.mem_we = 1; end
         if (trap) r.trap_n++;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      mem_ack  = 1'b0;
      r.cause = int'(trap_cause);
      r.dret  = int'(CW'(instret - start));
   endtask

   vec_t vecs[16];
   res_t r;
   bit   done;
   logic [CW-1:0] saved;
   int   bad, halt_lo;

   initial begin
      //                 id          br flat mlat cyc rf pc ps ws cs mn mw tn ca dr
      vecs[0]  = mk(ID_ADDI,   0, 1, 0,   4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[1]  = mk(ID_LW,     0, 1, 3,   7, 1, 1, 0, 1, 0, 3, 0, 0, 0, 1);
      vecs[2]  = mk(ID_SW,     0, 1, 2,   5, 0, 1, 0, 0, 0, 2, 1, 0, 0, 1);
      vecs[3]  = mk(ID_BEQ,    1, 1, 0,   3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      vecs[4]  = mk(ID_BEQ,    0, 1, 0,   3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[5]  = mk(ID_JALR,   0, 1, 0,   4, 1, 1, 2, 2, 0, 0, 0, 0, 0, 1);
      vecs[6]  = mk(ID_JAL,    0, 1, 0,   4, 1, 1, 1, 2, 0, 0, 0, 0, 0, 1);
      vecs[7]  = mk(ID_CSRRS,  0, 1, 0,   4, 1, 1, 0, 3, 1, 0, 0, 0, 0, 1);
      vecs[8]  = mk(6'd63,     0, 1, 0,   4, 0, 1, 3, 0, 0, 0, 0, 1, 0, 0);
      vecs[9]  = mk(ID_ECALL,  0, 1, 0,   4, 0, 1, 3, 0, 0, 0, 0, 1, 1, 0);
      vecs[10] = mk(ID_LW,     0, 1, 0,   8, 0, 1, 3, 0, 0, 4, 0, 1, 2, 0);
      vecs[11] = mk(ID_LW,     0, 1, 4,   8, 1, 1, 0, 1, 0, 4, 0, 0, 0, 1);
      vecs[12] = mk(ID_ADDI,   0, 0, 0,   5, 0, 1, 3, 0, 0, 0, 0, 1, 2, 0);
      vecs[13] = mk(ID_ADD,    0, 3, 0,   6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[14] = mk(ID_LBU,    0, 1, 1,   5, 1, 1, 0, 1, 0, 1, 0, 0, 0, 1);
      vecs[15] = mk(ID_BNE,    1, 1, 0,   3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);

      // Reset state
      #2 rst = 1'b1;
      #4;
      check("rst_strobes", {24'd0, imem_req, mem_req, mem_we, pc_we, rf_we, csr_we, trap, halt}, 0);
      check("rst_sels", {26'd0, pc_sel, wb_sel, trap_cause}, 0);
      check("rst_instret", 32'(instret), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check("rel_req", 32'(imem_req), 0);
      @(negedge clk);
      check("fetch_after_rst", 32'(imem_req), 1);

      // Table-driven instructions
      for (int i = 0; i < 16; i++) begin
         run_vec(vecs[i], r, done);
         check($sformatf("v%0d_done", i), 32'(done), 1);
         check($sformatf("v%0d_cycles", i), r.cycles, vecs[i].e.cycles);
         check($sformatf("v%0d_rf_we", i), r.rf_n, vecs[i].e.rf_n);
         check($sformatf("v%0d_pc_we", i), r.pc_n, vecs[i].e.pc_n);
         check($sformatf("v%0d_pc_sel", i), r.pc_sel, vecs[i].e.pc_sel);
         check($sformatf("v%0d_wb_sel", i), r.wb_sel, vecs[i].e.wb_sel);
         check($sformatf("v%0d_csr_we", i), r.csr_n, vecs[i].e.csr_n);
         check($sformatf("v%0d_mem_cyc", i), r.mem_n, vecs[i].e.mem_n);
         check($sformatf("v%0d_mem_we", i), r.mem_we, vecs[i].e.mem_we);
         check($sformatf("v%0d_trap", i), r.trap_n, vecs[i].e.trap_n);
         if (vecs[i].e.trap_n != 0)
            check($sformatf("v%0d_cause", i), r.cause, vecs[i].e.cause);
         check($sformatf("v%0d_instret_d", i), r.dret, vecs[i].e.dret);
         if (!done) begin
            $display("FAIL v%0d_stuck: got no return to FETCH expected return", i);
            n_err++;
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $fatal(1, "FSM stuck");
         end
      end

      // instret wrap at 2^CNT_W-1
      for (int k = 0; k < 20 && instret != CW'(15); k++) run_vec(vecs[0], r, done);
      check("wrap_pre", 32'(instret), 15);
      run_vec(vecs[0], r, done);
      check("wrap_post", 32'(instret), 0);

      // ebreak: sticky halt, no requests or strobes despite acks
      saved = instret;
      instr_id = ID_EBREAK;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      #1 check("ebreak_exec_pc_we", 32'(pc_we), 0);
      @(negedge clk);
      check("halt_set", 32'(halt), 1);
      bad = 0; halt_lo = 0;
      for (int c = 0; c < 100; c++) begin
         imem_ack = 1'b1;
         mem_ack  = c[0];
         #1;
         if (imem_req | mem_req | pc_we | rf_we | csr_we | trap) bad++;
         if (!halt) halt_lo++;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      mem_ack  = 1'b0;
      check("halt_quiet", bad, 0);
      check("halt_sticky", halt_lo, 0);
      check("halt_instret", 32'(instret), 32'(saved));

      // Reset clears halt; then reset asserted mid-FETCH drops imem_req at once
      rst = 1'b1;
      #1 check("rst_clears_halt", 32'(halt), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("fetch_after_halt_rst", 32'(imem_req), 1);
      @(posedge clk);
      #2 check("mid_fetch_req", 32'(imem_req), 1);
      rst = 1'b1;
      #1;
      check("rst_async_req", 32'(imem_req), 0);
      check("rst_async_all", {23'd0, mem_req, pc_we, rf_we, csr_we, trap, halt, pc_sel, wb_sel}, 0);
      check("rst_async_instret", 32'(instret), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("post_rst_reset_state", 32'(imem_req), 0);
      @(negedge clk);
      check("post_rst_fetch", 32'(imem_req), 1);
      run_vec(vecs[0], r, done);
      check("post_rst_addi_done", 32'(done), 1);
      check("post_rst_instret", 32'(instret), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Global bound so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "timeout");
   end

endmodule
